set_assoc_cache: RTL and testbench

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

---
 rtl/set_assoc_cache_pkg.sv | 27 ++
 rtl/cache_way_array.sv | 50 +++++
 rtl/set_assoc_cache.sv | 218 +++++++++++++++++++++
 tb/tb_set_assoc_cache.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/set_assoc_cache_pkg.sv
// Shared types and address-field helpers for the set-associative cache.
package set_assoc_cache_pkg;

  localparam int unsigned WordSizeDefault = 16;

  typedef enum logic [1:0] {StIdle, StLookup, StWback, StRefill} cache_state_e;

  function automatic int unsigned offset_bits(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned index_bits(input int unsigned sets);
    return $clog2(sets);
  endfunction

  // A direct-mapped-by-set build still needs a 1-bit index signal.
  function automatic int unsigned index_width(input int unsigned sets);
    return (sets > 1) ? $clog2(sets) : 1;
  endfunction

  function automatic int unsigned tag_bits(input int unsigned word_size,
                                           input int unsigned line_words,
                                           input int unsigned sets);
    return word_size - offset_bits(line_words) - index_bits(sets);
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// Tag/valid/dirty/data storage for one cache way: asynchronous read port, one write port.
module cache_way_array #(
  parameter int unsigned SETS     = 4,
  parameter int unsigned IdxW     = 2,
  parameter int unsigned TagW     = 12,
  parameter int unsigned LineBits = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [IdxW-1:0]     rd_idx_i,
  output logic [TagW-1:0]     rd_tag_o,
  output logic                rd_valid_o,
  output logic                rd_dirty_o,
  output logic [LineBits-1:0] rd_line_o,
  input  logic                we_i,
  input  logic [IdxW-1:0]     wr_idx_i,
  input  logic [TagW-1:0]     wr_tag_i,
  input  logic                wr_dirty_i,
  input  logic [LineBits-1:0] wr_line_i
);

  logic [SETS-1:0]     valid_q;
  logic [SETS-1:0]     dirty_q;
  logic [TagW-1:0]     tag_q  [SETS];
  logic [LineBits-1:0] line_q [SETS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      dirty_q[wr_idx_i] <= wr_dirty_i;
    end
  end

  // Payload arrays carry no reset; valid_q gates their use.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      line_q[wr_idx_i] <= wr_line_i;
    end
  end

  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_line_o  = line_q[rd_idx_i];

endmodule

// File: rtl/set_assoc_cache.sv
// Write-back, write-allocate, 1- or 2-way set-associative cache with LRU replacement.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module set_assoc_cache
  import set_assoc_cache_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = WordSizeDefault,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned SETS       = 4,
  parameter int unsigned WAYS       = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cpu_req,
  input  logic                       cpu_we,
  input  logic [WORD_SIZE-1:0]       cpu_addr,
  input  logic [WORD_SIZE-1:0]       cpu_wdata,
  output logic [WORD_SIZE-1:0]       cpu_rdata,
  output logic                       cpu_ready,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [WORD_SIZE-1:0]       mem_addr,
  output logic [WORD_SIZE*LINE_WORDS-1:0] mem_wdata,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] mem_rdata,
  input  logic                       mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [WORD_SIZE-1:0]       hit_count,
  output logic [WORD_SIZE-1:0]       miss_count
`endif
);

  localparam int unsigned OffW     = offset_bits(LINE_WORDS);
  localparam int unsigned IdxB     = index_bits(SETS);
  localparam int unsigned IdxW     = index_width(SETS);
  localparam int unsigned TagW     = tag_bits(WORD_SIZE, LINE_WORDS, SETS);
  localparam int unsigned LineBits = WORD_SIZE * LINE_WORDS;

  cache_state_e state_q, state_d;
  logic         victim_q, victim_d;
  logic [SETS-1:0] lru_q, lru_d;  // per set: index of the least recently used way

  logic [OffW-1:0] off;
  logic [IdxW-1:0] idx;
  logic [TagW-1:0] tag;

  assign off = cpu_addr[OffW-1:0];
  assign tag = cpu_addr[WORD_SIZE-1 -: TagW];

  if (IdxB > 0) begin : g_idx
    assign idx = cpu_addr[OffW +: IdxW];
  end else begin : g_no_idx
    assign idx = '0;
  end

  logic [TagW-1:0]     rd_tag  [WAYS];
  logic [LineBits-1:0] rd_line [WAYS];
  logic [WAYS-1:0]     rd_valid, rd_dirty, way_hit, way_we;
  logic [TagW-1:0]     wr_tag;
  logic                wr_dirty;
  logic [LineBits-1:0] wr_line;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way_array #(
      .SETS    (SETS),
      .IdxW    (IdxW),
      .TagW    (TagW),
      .LineBits(LineBits)
    ) u_way (
      .clk_i     (clk),
      .rst_i     (reset_n),
      .rd_idx_i  (idx),
      .rd_tag_o  (rd_tag[w]),
      .rd_valid_o(rd_valid[w]),
      .rd_dirty_o(rd_dirty[w]),
      .rd_line_o (rd_line[w]),
      .we_i      (way_we[w]),
      .wr_idx_i  (idx),
      .wr_tag_i  (wr_tag),
      .wr_dirty_i(wr_dirty),
      .wr_line_i (wr_line)
    );
    assign way_hit[w] = rd_valid[w] && (rd_tag[w] == tag);
  end

  function automatic logic [WORD_SIZE-1:0] line_addr(input logic [TagW-1:0] t,
                                                     input logic [IdxW-1:0] i);
    return (WORD_SIZE'(t) << (OffW + IdxB)) | (WORD_SIZE'(i) << OffW);
  endfunction

  logic                 hit, hit_way, victim_c;
  logic [LineBits-1:0]  hit_line, merged_line;
  logic [WORD_SIZE-1:0] hit_word;

  always_comb begin
    hit     = |way_hit;
    hit_way = 1'b0;
    if (WAYS == 2 && !way_hit[0]) hit_way = 1'b1;

    victim_c = lru_q[idx];
    if (WAYS == 1 || !rd_valid[0]) begin
      victim_c = 1'b0;
    end else if (!rd_valid[WAYS-1]) begin
      victim_c = 1'b1;
    end

    hit_line    = rd_line[hit_way];
    hit_word    = hit_line[WORD_SIZE*off +: WORD_SIZE];
    merged_line = hit_line;
    merged_line[WORD_SIZE*off +: WORD_SIZE] = cpu_wdata;
  end

  always_comb begin
    state_d   = state_q;
    victim_d  = victim_q;
    lru_d     = lru_q;
    way_we    = '0;
    wr_tag    = tag;
    wr_dirty  = 1'b0;
    wr_line   = merged_line;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    unique case (state_q)
      StIdle: begin
        if (cpu_req) state_d = StLookup;
      end
      StLookup: begin
        if (hit) begin
          cpu_ready = 1'b1;
          cpu_rdata = hit_word;
          if (cpu_we) begin
            way_we[hit_way] = 1'b1;
            wr_dirty        = 1'b1;
          end
          if (WAYS == 2) lru_d[idx] = ~hit_way;
          state_d = StIdle;
        end else begin
          victim_d = victim_c;
          state_d  = (rd_valid[victim_c] && rd_dirty[victim_c]) ? StWback : StRefill;
        end
      end
      StWback: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = line_addr(rd_tag[victim_q], idx);
        mem_wdata = rd_line[victim_q];
        if (mem_ack) state_d = StRefill;
      end
      StRefill: begin
        mem_req  = 1'b1;
        mem_addr = line_addr(tag, idx);
        if (mem_ack) begin
          way_we[victim_q] = 1'b1;
          wr_line          = mem_rdata;
          if (WAYS == 2) lru_d[idx] = ~victim_q;
          state_d = StLookup;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs read as idle for the whole time reset is held.
    if (reset_n) begin
      way_we    = '0;
      cpu_ready = 1'b0;
      cpu_rdata = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q  <= StIdle;
      victim_q <= 1'b0;
      lru_q    <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      lru_q    <= lru_d;
    end
  end

`ifdef CACHE_STATS_EN
  logic                 first_q;  // current LOOKUP is the first for this request
  logic [WORD_SIZE-1:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      first_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (state_q == StIdle && cpu_req) begin
        first_q <= 1'b1;
      end else if (state_q == StLookup && !hit) begin
        first_q <= 1'b0;
      end
      if (state_q == StLookup && first_q && hit && !(&hit_cnt_q)) begin
        hit_cnt_q <= hit_cnt_q + 1'b1;
      end
      if (state_q == StLookup && first_q && !hit && !(&miss_cnt_q)) begin
        miss_cnt_q <= miss_cnt_q + 1'b1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Scoreboard bench for set_assoc_cache: behavioural line memory plus per-scenario tasks.
module tb_set_assoc_cache;

  localparam int MemCycles = 3;
  localparam int MissLat   = 2 + MemCycles;
  localparam int DirtyLat  = 2 + 2 * MemCycles;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr;
  logic        cpu_ready, mem_req, mem_we, mem_ack;
  logic [63:0] mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  set_assoc_cache dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef CACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] mem_model [logic [15:0]];
  logic [15:0] exp_q [$];
  logic        txn_we_q [$];
  logic [15:0] txn_addr_q [$];
  logic [63:0] txn_wdata_q [$];
  bit          mem_hold = 1'b0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a * 16'd3 + 16'h1000;
  endfunction

  // Memory responder: acks after MemCycles cycles of mem_req, checks request stability.
  initial begin
    int          cnt;
    logic [15:0] held_addr;
    logic        held_we;
    cnt       = 0;
    held_addr = '0;
    held_we   = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!reset_n && mem_req) begin
        if (cnt == 0) begin
          held_addr = mem_addr;
          held_we   = mem_we;
        end else begin
          n_cmp++;
          if (mem_addr !== held_addr || mem_we !== held_we) begin
            n_fail++;
            $display("FAIL mem_stable: addr %h we %b, held addr %h we %b",
                     mem_addr, mem_we, held_addr, held_we);
          end
        end
        cnt++;
        if (cnt >= MemCycles && !mem_hold) begin
          cnt = 0;
          mem_ack = 1'b1;
          txn_we_q.push_back(mem_we);
          txn_addr_q.push_back(mem_addr);
          txn_wdata_q.push_back(mem_wdata);
          for (int i = 0; i < 4; i++) begin
            if (mem_we) mem_model[mem_addr + 16'(i)] = mem_wdata[16*i +: 16];
            mem_rdata[16*i +: 16] = mem_word(mem_addr + 16'(i));
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic txn_clear();
    txn_we_q.delete();
    txn_addr_q.delete();
    txn_wdata_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
  endtask

  task automatic do_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           output logic [15:0] rdata, output int cyc);
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!cpu_ready && cyc < 60);
    rdata = cpu_rdata;
    if (!cpu_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL access_timeout: addr %h no cpu_ready after %0d cycles", addr, cyc);
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cpu_req = 1'b1;
    cpu_addr = 16'h0012;
    repeat (2) @(negedge clk);
    n_cmp++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ready: got %b want 0", cpu_ready); end
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    n_cmp++; if (cpu_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_cpu_rdata: got %h want 0", cpu_rdata); end
    n_cmp++; if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    cpu_req = 1'b0;
    reset_n = 1'b0;
  endtask

  task automatic test_cold_load();
    logic [15:0] rd, exp;
    int cyc;
    do_reset();
    txn_clear();
    exp_q.push_back(mem_word(16'h0012));
    do_access(1'b0, 16'h0012, 16'h0, rd, cyc);
    exp = exp_q.pop_front();
    n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL cold_rdata: got %h want %h", rd, exp); end
    n_cmp++; if (cyc !== MissLat) begin n_fail++; $display("FAIL cold_latency: got %0d want %0d", cyc, MissLat); end
    n_cmp++;
    if (txn_we_q.size() !== 1) begin
      n_fail++; $display("FAIL cold_txn_count: got %0d want 1", txn_we_q.size());
    end else begin
      n_cmp++; if (txn_we_q[0] !== 1'b0) begin n_fail++; $display("FAIL cold_mem_we: got %b want 0", txn_we_q[0]); end
      n_cmp++; if (txn_addr_q[0] !== 16'h0010) begin n_fail++; $display("FAIL cold_mem_addr: got %h want 0010", txn_addr_q[0]); end
    end
  endtask

  task automatic test_store_hit();
    logic [15:0] rd, exp;
    int cyc;
    txn_clear();
    do_access(1'b1, 16'h0012, 16'hBEEF, rd, cyc);
    n_cmp++; if (cyc !== 1) begin n_fail++; $display("FAIL store_latency: got %0d want 1", cyc); end
    exp_q.push_back(16'hBEEF);
    do_access(1'b0, 16'h0012, 16'h0, rd, cyc);
    exp = exp_q.pop_front();
    n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL store_reload: got %h want %h", rd, exp); end
    n_cmp++; if (cyc !== 1) begin n_fail++; $display("FAIL load_hit_latency: got %0d want 1", cyc); end
    n_cmp++; if (txn_we_q.size() !== 0) begin n_fail++; $display("FAIL store_no_mem: got %0d txns want 0", txn_we_q.size()); end
  endtask

  task automatic test_lru();
    logic [15:0] rd, exp;
    int cyc;
    do_reset();
    do_access(1'b0, 16'h0010, 16'h0, rd, cyc);
    do_access(1'b0, 16'h0050, 16'h0, rd, cyc);
    do_access(1'b0, 16'h0010, 16'h0, rd, cyc);
    n_cmp++; if (cyc !== 1) begin n_fail++; $display("FAIL lru_touch_hit: got %0d cycles want 1", cyc); end
    txn_clear();
    exp_q.push_back(mem_word(16'h0091));
    do_access(1'b0, 16'h0091, 16'h0, rd, cyc);
    exp = exp_q.pop_front();
    n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL lru_rdata: got %h want %h", rd, exp); end
    n_cmp++;
    if (txn_we_q.size() !== 1 || txn_we_q[0] !== 1'b0 || txn_addr_q[0] !== 16'h0090) begin
      n_fail++; $display("FAIL lru_clean_victim: %0d txns, first we %b addr %h; want one refill of 0090",
                          txn_we_q.size(), txn_we_q[0], txn_addr_q[0]);
    end
    do_access(1'b0, 16'h0010, 16'h0, rd, cyc);
    n_cmp++; if (cyc !== 1) begin n_fail++; $display("FAIL lru_mru_kept: got %0d cycles want 1", cyc); end
    do_access(1'b0, 16'h0050, 16'h0, rd, cyc);
    n_cmp++; if (cyc !== MissLat) begin n_fail++; $display("FAIL lru_evicted: got %0d cycles want %0d", cyc, MissLat); end
  endtask

  task automatic test_dirty_victim();
    logic [15:0] rd, exp;
    logic [63:0] exp_line;
    int cyc;
    do_reset();
    do_access(1'b0, 16'h0010, 16'h0, rd, cyc);
    do_access(1'b0, 16'h0050, 16'h0, rd, cyc);
    do_access(1'b1, 16'h0051, 16'h5A5A, rd, cyc);
    do_access(1'b0, 16'h0010, 16'h0, rd, cyc);
    for (int i = 0; i < 4; i++) exp_line[16*i +: 16] = mem_word(16'h0050 + 16'(i));
    exp_line[31:16] = 16'h5A5A;
    txn_clear();
    exp_q.push_back(mem_word(16'h00D0));
    do_access(1'b0, 16'h00D0, 16'h0, rd, cyc);
    exp = exp_q.pop_front();
    n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL dirty_rdata: got %h want %h", rd, exp); end
    n_cmp++; if (cyc !== DirtyLat) begin n_fail++; $display("FAIL dirty_latency: got %0d want %0d", cyc, DirtyLat); end
    n_cmp++;
    if (txn_we_q.size() !== 2) begin
      n_fail++; $display("FAIL dirty_txn_count: got %0d want 2", txn_we_q.size());
    end else begin
      n_cmp++; if (txn_we_q[0] !== 1'b1 || txn_addr_q[0] !== 16'h0050) begin
        n_fail++; $display("FAIL wback_hdr: we %b addr %h, want 1 0050", txn_we_q[0], txn_addr_q[0]); end
      n_cmp++; if (txn_wdata_q[0] !== exp_line) begin
        n_fail++; $display("FAIL wback_data: got %h want %h", txn_wdata_q[0], exp_line); end
      n_cmp++; if (txn_we_q[1] !== 1'b0 || txn_addr_q[1] !== 16'h00D0) begin
        n_fail++; $display("FAIL refill_after_wback: we %b addr %h, want 0 00d0", txn_we_q[1], txn_addr_q[1]); end
    end
    exp_q.push_back(16'h5A5A);
    do_access(1'b0, 16'h0051, 16'h0, rd, cyc);
    exp = exp_q.pop_front();
    n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL wback_reload: got %h want %h", rd, exp); end
  endtask

  task automatic test_reset_mid_refill();
    logic [15:0] rd;
    int cyc, wait_cyc;
    do_reset();
    do_access(1'b0, 16'h0010, 16'h0, rd, cyc);
    mem_hold = 1'b1;
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 16'h0050;
    wait_cyc = 0;
    while (!mem_req && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL midrefill_req: got %b want 1", mem_req); end
    reset_n = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL midrefill_drop: got %b want 0", mem_req); end
    reset_n  = 1'b0;
    mem_hold = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL midrefill_idle: got %b want 0", mem_req); end
    txn_clear();
    do_access(1'b0, 16'h0010, 16'h0, rd, cyc);
    n_cmp++; if (cyc !== MissLat) begin n_fail++; $display("FAIL midrefill_reload_miss: got %0d want %0d", cyc, MissLat); end
    n_cmp++; if (rd !== mem_word(16'h0010)) begin n_fail++; $display("FAIL midrefill_rdata: got %h want %h", rd, mem_word(16'h0010)); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] shadow [4];
    logic [15:0] rd, exp, a, d;
    int cyc;
    do_reset();
    do_access(1'b0, 16'h0020, 16'h0, rd, cyc);
    for (int i = 0; i < 4; i++) shadow[i] = mem_word(16'h0020 + 16'(i));
    txn_clear();
    for (int k = 0; k < 6; k++) begin
      a = 16'h0020 + 16'($urandom_range(0, 3));
      d = 16'($urandom);
      shadow[a[1:0]] = d;
      do_access(1'b1, a, d, rd, cyc);
      n_cmp++; if (cyc !== 1) begin n_fail++; $display("FAIL b2b_store_lat: addr %h got %0d want 1", a, cyc); end
    end
    for (int i = 0; i < 4; i++) begin
      a = 16'h0020 + 16'(i);
      exp_q.push_back(shadow[i]);
      do_access(1'b0, a, 16'h0, rd, cyc);
      exp = exp_q.pop_front();
      n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL b2b_load: addr %h got %h want %h", a, rd, exp); end
    end
    n_cmp++; if (txn_we_q.size() !== 0) begin n_fail++; $display("FAIL b2b_no_mem: got %0d txns want 0", txn_we_q.size()); end
  endtask

`ifdef CACHE_STATS_EN
  task automatic test_stats();
    logic [15:0] rd;
    int cyc;
    do_reset();
    do_access(1'b0, 16'h0012, 16'h0, rd, cyc);
    do_access(1'b1, 16'h0012, 16'hBEEF, rd, cyc);
    do_access(1'b0, 16'h0012, 16'h0, rd, cyc);
    @(negedge clk);
    n_cmp++; if (hit_count !== 16'd2) begin n_fail++; $display("FAIL stats_hits: got %0d want 2", hit_count); end
    n_cmp++; if (miss_count !== 16'd1) begin n_fail++; $display("FAIL stats_misses: got %0d want 1", miss_count); end
  endtask
`endif

  initial begin
    reset_n   = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    test_reset();
    test_cold_load();
    test_store_hit();
    test_lru();
    test_dirty_victim();
    test_reset_mid_refill();
    test_back_to_back();
`ifdef CACHE_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
